// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester sequential multiplier arbiter.
package mul_arb_pkg;

    localparam int N_REQ = 2;
    localparam int ID_W  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mul_seq_engine.sv
// Repeated-addition multiplier datapath: load clears the accumulator and arms the
// step counter with the multiplier; each step adds the multiplicand once.
module mul_seq_engine #(
    parameter int SIZE = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              step,
    input  logic [SIZE-1:0]   a_in,
    input  logic [SIZE-1:0]   b_in,
    output logic [2*SIZE-1:0] acc,
    output logic              done
);

    logic [SIZE-1:0] a_q;
    logic [SIZE-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            cnt_q <= '0;
            acc   <= '0;
        end else if (load) begin
            a_q   <= a_in;
            cnt_q <= b_in;
            acc   <= '0;
        end else if (step && (cnt_q != '0)) begin
            acc   <= acc + {{SIZE{1'b0}}, a_q};
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/mul_arbiter.sv
// Round-robin front end for a shared sequential multiplier: grants one of two
// requesters in IDLE, runs the engine, then holds the product until consumed.
module mul_arbiter
    import mul_arb_pkg::*;
#(
    parameter int SIZE = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*SIZE-1:0]   req_a,
    input  logic [N_REQ*SIZE-1:0]   req_b,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [2*SIZE-1:0]       rsp_result,
    input  logic                    rsp_ready,
    output logic                    busy
);

    state_t            state_q, state_d;
    logic [ID_W-1:0]   ptr_q;
    logic [ID_W-1:0]   id_q;
    logic [ID_W-1:0]   grant;
    logic              any_valid;
    logic [SIZE-1:0]   sel_a, sel_b;
    logic              load, step, rsp_set, rsp_clr;
    logic [2*SIZE-1:0] eng_acc;
    logic              eng_done;

    // The pointer only matters under contention; a lone requester always wins.
    assign any_valid = |req_valid;
    assign grant     = (&req_valid) ? ptr_q : req_valid[1];
    assign sel_a     = grant[0] ? req_a[2*SIZE-1:SIZE] : req_a[SIZE-1:0];
    assign sel_b     = grant[0] ? req_b[2*SIZE-1:SIZE] : req_b[SIZE-1:0];

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        load      = 1'b0;
        step      = 1'b0;
        rsp_set   = 1'b0;
        rsp_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                // rst_n gating keeps req_ready low while reset is held.
                if (any_valid && rst_n) begin
                    req_ready[grant] = 1'b1;
                    load             = 1'b1;
                    state_d          = RUN;
                end
            end
            RUN: begin
                if (eng_done) begin
                    rsp_set = 1'b1;
                    state_d = DONE;
                end else begin
                    step = 1'b1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    rsp_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_result <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                id_q  <= grant;
                ptr_q <= ~grant;
            end
            // rsp_result is left untouched on handshake; rsp_valid qualifies it.
            if (rsp_set) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= id_q;
                rsp_result <= eng_acc;
            end else if (rsp_clr) begin
                rsp_valid  <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

    mul_seq_engine #(
        .SIZE(SIZE)
    ) u_engine (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .step  (step),
        .a_in  (sel_a),
        .b_in  (sel_b),
        .acc   (eng_acc),
        .done  (eng_done)
    );

endmodule

// File: tb/tb_mul_arbiter.sv
// Self-checking bench for mul_arbiter: transaction-level reference model compared
// every cycle, plus directed literal scenarios and a randomized soak.
module tb_mul_arbiter;

    localparam int SIZE = 8;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b1;
    logic [1:0]  req_valid  = 2'b00;
    logic [15:0] req_a      = '0;
    logic [15:0] req_b      = '0;
    logic        rsp_ready  = 1'b0;
    logic [1:0]  req_ready;
    logic        rsp_valid;
    logic [0:0]  rsp_id;
    logic [15:0] rsp_result;
    logic        busy;

    always #5 clk = ~clk;

    mul_arbiter #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .rsp_ready  (rsp_ready),
        .busy       (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit          m_busy = 0;
    bit          m_ptr  = 0;
    bit          m_id   = 0;
    bit          m_rv   = 0;
    bit          m_rid  = 0;
    int          m_wait = 0;
    logic [15:0] m_prod = '0;
    logic [15:0] m_res  = '0;
    bit          m_g;
    logic [7:0]  m_a, m_b;

    function automatic bit pick(input logic [1:0] v, input bit p);
        if (v == 2'b11) return p;
        return v[1];
    endfunction

    assign m_g = pick(req_valid, m_ptr);
    assign m_a = m_g ? req_a[15:8] : req_a[7:0];
    assign m_b = m_g ? req_b[15:8] : req_b[7:0];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_ptr <= 0; m_id <= 0; m_rv <= 0; m_rid <= 0;
            m_wait <= 0; m_prod <= '0; m_res <= '0;
        end else if (!m_busy) begin
            if (req_valid != 2'b00) begin
                m_busy <= 1;
                m_id   <= m_g;
                m_ptr  <= !m_g;
                m_prod <= 16'(m_a) * 16'(m_b);
                m_wait <= int'(m_b) + 1;
            end
        end else if (m_wait > 1) begin
            m_wait <= m_wait - 1;
        end else if (m_wait == 1) begin
            m_wait <= 0;
            m_rv   <= 1;
            m_rid  <= m_id;
            m_res  <= m_prod;
        end else if (rsp_ready) begin
            m_rv   <= 0;
            m_busy <= 0;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [1:0] exp_rr;
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            exp_rr = (rst_n && !m_busy && req_valid != 2'b00) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
            check("req_ready", 32'(req_ready), 32'(exp_rr));
            check("busy", 32'(busy), 32'(m_busy));
            check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
            check("rsp_id", 32'(rsp_id), 32'(m_rid));
            check("rsp_result", 32'(rsp_result), 32'(m_res));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle();
        int k = 0;
        rsp_ready = 1'b1;
        while (busy && k < 600) begin
            @(negedge clk);
            k++;
        end
        check("idle_reached", 32'(busy), 0);
    endtask

    task automatic run_one(input bit idx, input logic [7:0] a, input logic [7:0] b, output int lat);
        wait_idle();
        @(negedge clk);
        if (idx) begin req_a[15:8] = a; req_b[15:8] = b; req_valid = 2'b10; end
        else     begin req_a[7:0]  = a; req_b[7:0]  = b; req_valid = 2'b01; end
        rsp_ready = 1'b1;
        #1 check("grant", 32'(req_ready), idx ? 2 : 1);
        @(posedge clk);
        #1 check("ready_one_cycle", 32'(req_ready), 0);
        req_valid = 2'b00;
        lat = 0;
        while (lat < 300) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
        end
    endtask

    initial begin
        int lat;
        int got;
        int cyc;
        int seen;
        reset_dut();
        chk_en = 1'b1;
        check("reset_busy", 32'(busy), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);

        // Single requester, 7*5.
        run_one(1'b0, 8'd7, 8'd5, lat);
        check("basic_latency", lat, 6);
        check("basic_id", 32'(rsp_id), 0);
        check("basic_result", 32'(rsp_result), 35);

        // Contention from reset: alternating 0,1,0,1.
        reset_dut();
        @(negedge clk);
        req_valid = 2'b11;
        req_a = {8'd5, 8'd3};
        req_b = {8'd6, 8'd4};
        rsp_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (rsp_valid) begin
                check("contend_id", 32'(rsp_id), got % 2);
                check("contend_result", 32'(rsp_result), (got % 2) ? 30 : 12);
                got++;
            end
        end
        check("contend_count", got, 4);
        req_valid = 2'b00;

        // Corners.
        run_one(1'b1, 8'd200, 8'd0, lat);
        check("b0_latency", lat, 1);
        check("b0_result", 32'(rsp_result), 0);
        check("b0_id", 32'(rsp_id), 1);
        run_one(1'b0, 8'd255, 8'd255, lat);
        check("max_latency", lat, 256);
        check("max_result", 32'(rsp_result), 65025);
        run_one(1'b1, 8'd0, 8'd9, lat);
        check("a0_latency", lat, 10);
        check("a0_result", 32'(rsp_result), 0);

        // Backpressure in DONE.
        wait_idle();
        @(negedge clk);
        req_valid = 2'b10;
        req_a[15:8] = 8'd9;
        req_b[15:8] = 8'd3;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 2'b00;
        cyc = 0;
        while (!rsp_valid && cyc < 300) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("bp_rsp_seen", 32'(rsp_valid), 1);
        req_valid = 2'b11;
        repeat (10) begin
            @(negedge clk);
            #1;
            check("bp_valid", 32'(rsp_valid), 1);
            check("bp_id", 32'(rsp_id), 1);
            check("bp_result", 32'(rsp_result), 27);
            check("bp_req_ready", 32'(req_ready), 0);
            check("bp_busy", 32'(busy), 1);
        end
        req_valid = 2'b00;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_released", 32'(rsp_valid), 0);
        check("bp_result_kept", 32'(rsp_result), 27);

        // Reset mid-RUN abandons the operation.
        wait_idle();
        @(negedge clk);
        req_valid = 2'b01;
        req_a[7:0] = 8'd3;
        req_b[7:0] = 8'd100;
        @(posedge clk);
        #1 req_valid = 2'b00;
        repeat (40) @(posedge clk);
        #3 rst_n = 1'b0;
        req_valid = 2'b11;
        #1;
        check("rst_req_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_id", 32'(rsp_id), 0);
        check("rst_rsp_result", 32'(rsp_result), 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        seen = 0;
        repeat (150) begin
            @(posedge clk);
            #1 if (rsp_valid) seen++;
        end
        check("no_rsp_after_reset", seen, 0);
        @(negedge clk);
        req_valid = 2'b11;
        #1 check("post_reset_winner", 32'(req_ready), 1);

        // Randomized soak against the model.
        repeat (3000) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 499) != 0);
            req_valid = 2'($urandom_range(0, 3));
            req_a     = 16'($urandom);
            req_b[7:0]  = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            req_b[15:8] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 12));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        #3 chk_en = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
